// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID/EX/MEM/WB control pipeline with branch flush; load-use stall and stall counter enabled by CTRL_LOADUSE_EN
module ctrl_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [8:0]       id_ctrl,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             branch_taken,
  output logic [8:0]       ex_ctrl,
  output logic [4:0]       mem_ctrl,
  output logic [1:0]       wb_ctrl,
  output logic [4:0]       ex_dst,
  output logic [4:0]       mem_dst,
  output logic [4:0]       wb_dst,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic             stall_if,
  output logic             flush_ifid,
  output logic [CNT_W-1:0] stall_count
);
  logic [8:0] ex_ctrl_q, ex_ctrl_d;
  logic [4:0] ex_dst_q, ex_dst_d, mem_ctrl_q, mem_ctrl_d, mem_dst_q, mem_dst_d, wb_dst_q, wb_dst_d;
  logic [1:0] wb_ctrl_q, wb_ctrl_d;
  logic       ex_valid_q, ex_valid_d, mem_valid_q, mem_valid_d, wb_valid_q, wb_valid_d;
  logic       load_use, ex_kill;
`ifdef CTRL_LOADUSE_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign load_use = ex_valid_q & ex_ctrl_q[4] & (|ex_dst_q) & id_valid & ((ex_dst_q == id_rs) | (ex_dst_q == id_rt));
  assign stall_if = load_use & ~branch_taken;
  // Stall cycle counter that sticks at all-ones instead of wrapping
  always_comb cnt_d = (stall_if && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  // Counter register
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign stall_count = cnt_q;
`else
  logic unused_rs;
  assign unused_rs   = ^id_rs;
  assign load_use    = 1'b0;
  assign stall_if    = 1'b0;
  assign stall_count = '0;
`endif
  assign flush_ifid = branch_taken;
  // A stalled or squashed ID instruction enters EX as a bubble; a bubble carries dst 0
  assign ex_kill = ~id_valid | branch_taken | load_use;
  // Next-state for every stage; branch squashes ID and EX, MEM always drains into WB
  always_comb begin
    ex_ctrl_d   = ex_kill ? '0 : id_ctrl;
    ex_dst_d    = ex_kill ? '0 : (id_ctrl[8] ? id_rd : id_rt);
    ex_valid_d  = ~ex_kill;
    mem_ctrl_d  = branch_taken ? '0 : ex_ctrl_q[6:2];
    mem_dst_d   = branch_taken ? '0 : ex_dst_q;
    mem_valid_d = ~branch_taken & ex_valid_q;
    wb_ctrl_d   = mem_ctrl_q[4:3];
    wb_dst_d    = mem_dst_q;
    wb_valid_d  = mem_valid_q;
  end
  // Stage registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ex_ctrl_q   <= '0;
      ex_dst_q    <= '0;
      ex_valid_q  <= 1'b0;
      mem_ctrl_q  <= '0;
      mem_dst_q   <= '0;
      mem_valid_q <= 1'b0;
      wb_ctrl_q   <= '0;
      wb_dst_q    <= '0;
      wb_valid_q  <= 1'b0;
    end else begin
      ex_ctrl_q   <= ex_ctrl_d;
      ex_dst_q    <= ex_dst_d;
      ex_valid_q  <= ex_valid_d;
      mem_ctrl_q  <= mem_ctrl_d;
      mem_dst_q   <= mem_dst_d;
      mem_valid_q <= mem_valid_d;
      wb_ctrl_q   <= wb_ctrl_d;
      wb_dst_q    <= wb_dst_d;
      wb_valid_q  <= wb_valid_d;
    end
  assign ex_ctrl   = ex_ctrl_q;
  assign ex_dst    = ex_dst_q;
  assign ex_valid  = ex_valid_q;
  assign mem_ctrl  = mem_ctrl_q;
  assign mem_dst   = mem_dst_q;
  assign mem_valid = mem_valid_q;
  assign wb_ctrl   = wb_ctrl_q;
  assign wb_dst    = wb_dst_q;
  assign wb_valid  = wb_valid_q;
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: table-driven check of ctrl_pipe plus reset, saturation and async-reset sequences
module tb_ctrl_pipe;
  localparam int CNT_W = 3;
`ifdef CTRL_LOADUSE_EN
  localparam bit LU = 1'b1;
`else
  localparam bit LU = 1'b0;
`endif
  localparam logic [8:0] RTY = 9'b100100010;
  localparam logic [8:0] LW  = 9'b011110000;
  localparam logic [8:0] BEQ = 9'b000000101;
  logic clk = 1'b0, reset = 1'b1, id_valid = 1'b0, branch_taken = 1'b0;
  logic [8:0] id_ctrl = '0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic [8:0] ex_ctrl;
  logic [4:0] mem_ctrl, ex_dst, mem_dst, wb_dst;
  logic [1:0] wb_ctrl;
  logic ex_valid, mem_valid, wb_valid, stall_if, flush_ifid;
  logic [CNT_W-1:0] stall_count;
  int checks = 0, failures = 0;
  ctrl_pipe #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .branch_taken(branch_taken), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst), .ex_valid(ex_valid), .mem_valid(mem_valid),
    .wb_valid(wb_valid), .stall_if(stall_if), .flush_ifid(flush_ifid), .stall_count(stall_count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic v; logic [8:0] c; logic [4:0] rs, rt, rd; logic bt; logic st;
    logic [8:0] exc; logic [4:0] exd; logic exv;
    logic [4:0] mc; logic [4:0] md; logic mv;
    logic [1:0] wc; logic [4:0] wd; logic wv;
    logic [CNT_W-1:0] cnt;
  } vec_t;
  vec_t tbl [15];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [8:0] c, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic bt);
    @(negedge clk);
    id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd; branch_taken = bt;
  endtask
  task automatic step(input logic v, input logic [8:0] c, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic bt);
    drive(v, c, rs, rt, rd, bt);
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl[0]  = '{1, RTY, 1, 3, 5, 0, 0,   RTY, 5, 1,   0, 0, 0,   0, 0, 0,   0};
    tbl[1]  = '{0, 0,   0, 0, 0, 0, 0,   0, 0, 0,   5'b01000, 5, 1,   0, 0, 0,   0};
    tbl[2]  = '{0, 0,   0, 0, 0, 0, 0,   0, 0, 0,   0, 0, 0,   2'b01, 5, 1,   0};
    tbl[3]  = '{1, LW,  2, 8, 0, 0, 0,   LW, 8, 1,   0, 0, 0,   0, 0, 0,   0};
    tbl[4]  = '{1, RTY, 8, 4, 9, 0, LU,  LU ? 9'd0 : RTY, LU ? 5'd0 : 5'd9, !LU,
                5'b11100, 8, 1,   0, 0, 0,   CNT_W'(LU)};
    tbl[5]  = '{1, RTY, 8, 4, 9, 0, 0,   RTY, 9, 1,   LU ? 5'd0 : 5'b01000, LU ? 5'd0 : 5'd9, !LU,
                2'b11, 8, 1,   CNT_W'(LU)};
    tbl[6]  = '{1, LW,  2, 0, 0, 0, 0,   LW, 0, 1,   5'b01000, 9, 1,
                LU ? 2'b00 : 2'b01, LU ? 5'd0 : 5'd9, !LU,   CNT_W'(LU)};
    tbl[7]  = '{1, RTY, 0, 0, 7, 0, 0,   RTY, 7, 1,   5'b11100, 0, 1,   2'b01, 9, 1,   CNT_W'(LU)};
    tbl[8]  = '{1, BEQ, 1, 2, 0, 0, 0,   BEQ, 2, 1,   5'b01000, 7, 1,   2'b11, 0, 1,   CNT_W'(LU)};
    tbl[9]  = '{1, LW,  1, 6, 0, 0, 0,   LW, 6, 1,   5'b00001, 2, 1,   2'b01, 7, 1,   CNT_W'(LU)};
    tbl[10] = '{1, RTY, 6, 3, 10, 1, 0,  0, 0, 0,   0, 0, 0,   2'b00, 2, 1,   CNT_W'(LU)};
    tbl[11] = '{0, 0,   0, 0, 0, 0, 0,   0, 0, 0,   0, 0, 0,   0, 0, 0,   CNT_W'(LU)};
    tbl[12] = '{1, LW,  1, 11, 0, 0, 0,  LW, 11, 1,   0, 0, 0,   0, 0, 0,   CNT_W'(LU)};
    tbl[13] = '{1, RTY, 1, 11, 12, 0, LU,  LU ? 9'd0 : RTY, LU ? 5'd0 : 5'd12, !LU,
                5'b11100, 11, 1,   0, 0, 0,   CNT_W'(2 * LU)};
    tbl[14] = '{1, RTY, 1, 11, 12, 0, 0,  RTY, 12, 1,   LU ? 5'd0 : 5'b01000, LU ? 5'd0 : 5'd12, !LU,
                2'b11, 11, 1,   CNT_W'(2 * LU)};
    // reset state
    #3;
    chk("rst_async_ex_valid", 32'(ex_valid), 0);
    chk("rst_stall_if", 32'(stall_if), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_ctrl", 32'(ex_ctrl), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_stall_count", 32'(stall_count), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].c, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].bt);
      #1;
      chk($sformatf("v%0d_stall_if", i), 32'(stall_if), 32'(tbl[i].st));
      chk($sformatf("v%0d_flush", i), 32'(flush_ifid), 32'(tbl[i].bt));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ex_ctrl", i), 32'(ex_ctrl), 32'(tbl[i].exc));
      chk($sformatf("v%0d_ex_dst", i), 32'(ex_dst), 32'(tbl[i].exd));
      chk($sformatf("v%0d_ex_valid", i), 32'(ex_valid), 32'(tbl[i].exv));
      chk($sformatf("v%0d_mem_ctrl", i), 32'(mem_ctrl), 32'(tbl[i].mc));
      chk($sformatf("v%0d_mem_dst", i), 32'(mem_dst), 32'(tbl[i].md));
      chk($sformatf("v%0d_mem_valid", i), 32'(mem_valid), 32'(tbl[i].mv));
      chk($sformatf("v%0d_wb_ctrl", i), 32'(wb_ctrl), 32'(tbl[i].wc));
      chk($sformatf("v%0d_wb_dst", i), 32'(wb_dst), 32'(tbl[i].wd));
      chk($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'(tbl[i].wv));
      chk($sformatf("v%0d_stall_count", i), 32'(stall_count), 32'(tbl[i].cnt));
    end
    // counter saturation: climb to all-ones minus one, then three more stalls
    for (int i = 0; i < 4; i++) begin
      step(1, LW, 1, 8, 0, 0);
      step(1, RTY, 8, 2, 9, 0);
    end
    chk("sat_pre", 32'(stall_count), LU ? 32'd6 : 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1, LW, 1, 8, 0, 0);
      drive(1, RTY, 8, 2, 9, 0);
      #1;
      chk($sformatf("sat_stall_if%0d", i), 32'(stall_if), 32'(LU));
      @(posedge clk);
      #1;
    end
    chk("sat_final", 32'(stall_count), LU ? 32'd7 : 32'd0);
    // asynchronous reset in the middle of a stall
    step(1, LW, 1, 8, 0, 0);
    drive(1, RTY, 8, 2, 9, 0);
    #1;
    chk("ar_stall_before", 32'(stall_if), 32'(LU));
    chk("ar_ex_valid_before", 32'(ex_valid), 1);
    #1;
    reset = 1'b1;
    #1;
    chk("ar_ex_ctrl", 32'(ex_ctrl), 0);
    chk("ar_ex_dst", 32'(ex_dst), 0);
    chk("ar_ex_valid", 32'(ex_valid), 0);
    chk("ar_mem", 32'({mem_ctrl, mem_dst, mem_valid}), 0);
    chk("ar_wb", 32'({wb_ctrl, wb_dst, wb_valid}), 0);
    chk("ar_stall_if", 32'(stall_if), 0);
    chk("ar_stall_count", 32'(stall_count), 0);
    @(posedge clk);
    drive(1, RTY, 1, 3, 5, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ex_ctrl", 32'(ex_ctrl), 32'(RTY));
    chk("post_rst_ex_dst", 32'(ex_dst), 5);
    chk("post_rst_mem_valid", 32'(mem_valid), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of load-use stall counter.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: id_valid  in  1  ID stage holds a valid instruction.
REQ-005 SHALL have port: id_ctrl  in  9  decoded bundle {RegDst,ALUSrc,MemToReg,RegWrite,MemRead,MemWrite,Branch,ALUOp[1:0]}, bit 8 = RegDst.
REQ-006 SHALL have port: id_rs, id_rt, id_rd  in  5 each  ID instruction register fields.
REQ-007 SHALL have port: branch_taken  in  1  branch resolved taken in MEM stage.
REQ-008 SHALL have port: ex_ctrl  out  9  EX-stage bundle, same layout as id_ctrl.
REQ-009 SHALL have port: mem_ctrl  out  5  {MemToReg,RegWrite,MemRead,MemWrite,Branch}.
REQ-010 SHALL have port: wb_ctrl  out  2  {MemToReg,RegWrite}.
REQ-011 SHALL have port: ex_dst, mem_dst, wb_dst  out  5 each  destination register per stage.
REQ-012 SHALL have port: ex_valid, mem_valid, wb_valid  out  1 each  stage holds real instruction.
REQ-013 SHALL have port: stall_if  out  1  combinational; freeze PC and IF/ID register.
REQ-014 SHALL have port: flush_ifid  out  1  combinational; equals branch_taken.
REQ-015 SHALL have port: stall_count  out  CNT_W  saturating count of load-use stall cycles.

Function
REQ-016 SHALL advance every cycle: ID->EX, EX->MEM (field subset), MEM->WB (field subset); no stage ever holds.
REQ-017 SHALL capture ex_dst = id_ctrl[8] ? id_rd : id_rt on ID->EX; mem_dst/wb_dst copy the previous stage.
REQ-018 SHALL load EX with a bubble (ctrl=0, dst=0, valid=0) when id_valid=0.
REQ-019 SHALL detect load-use: ex_valid & ex_ctrl MemRead & ex_dst!=0 & id_valid & (ex_dst==id_rs | ex_dst==id_rt).
REQ-020 SHALL on load-use assert stall_if the same cycle and load a bubble into EX; the stall lasts exactly one cycle because the load then leaves EX.
REQ-021 SHALL on branch_taken load bubbles into EX and MEM (squash ID and EX instructions); MEM->WB proceeds normally.
REQ-022 SHALL give flush priority: with branch_taken=1, stall_if=0 and stall_count is not incremented.
REQ-023 SHALL increment stall_count by 1 per stall_if cycle, saturating at all-ones with no wrap.
REQ-024 SHALL register all stage outputs; latency ID->EX = 1, ID->MEM = 2, ID->WB = 3 cycles.

Reset
REQ-025 SHALL on reset=1, asynchronously and regardless of clk, drive all ctrl, dst, valid outputs and stall_count to 0.
REQ-026 SHALL treat reset mid-stall or mid-flush as dominant; the first post-reset edge samples ID normally.
REQ-027 SHALL keep stall_if=0 while reset=1, since ex_valid=0.

Configuration
REQ-028 SHALL support macro CTRL_LOADUSE_EN: when defined, REQ-019/020/023 are active.
REQ-029 SHALL, when CTRL_LOADUSE_EN is undefined, tie stall_if to 0, hold stall_count at 0, and include no hazard comparators; all other behaviour is unchanged.

Verification
REQ-030 SHALL cover: R-type id_ctrl=9'b100100010, rd=5, rt=3 -> ex_ctrl=9'b100100010, ex_dst=5 after 1 cycle, mem_ctrl=5'b01000 after 2, wb_ctrl=2'b01 after 3.
REQ-031 SHALL cover: LW id_ctrl=9'b011110000, rt=8, followed by a consumer with rs=8 -> stall_if=1 for one cycle, EX bubble, stall_count=1; consumer enters EX on the next cycle.
REQ-032 SHALL cover: LW with rt=0 followed by a consumer with rs=0 -> no stall; stall_if stays 0.
REQ-033 SHALL cover: BEQ 9'b000000101 in MEM with branch_taken=1, while load-use is present -> ex/mem valid=0, stall_if=0, wb receives the BEQ bundle, stall_count unchanged.
REQ-034 SHALL cover: preset stall_count to 0xFFFE, then issue 3 load-use stalls -> saturates at 0xFFFF.
REQ-035 SHALL cover: assert reset between clock edges during a stall -> all outputs 0 immediately, without waiting for a clock edge.
